// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from four byte requesters.
// Optional received-byte echo (highest priority) is built when UART_TX_ARB_ECHO_EN is defined.
module uart_tx_arbiter #(
    parameter int START_TIMEOUT = 16
) (
    input  logic        iCE_CLK,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [31:0] req_byte,
    output logic [3:0]  ack,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    input  logic        is_transmitting,
    input  logic        received,
    input  logic [7:0]  rx_byte,
    output logic        busy,
    output logic        timeout_err,
    output logic [1:0]  dbg_state_o
);

    localparam int CNT_W = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(START_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_START = 2'd1,
        S_WAIT_DONE  = 2'd2
    } state_e;

    // Handshake: a requester holds req[i] high until it sees the one-cycle ack[i];
    // ack[i] is issued in the same cycle as transmit, with tx_byte already valid.
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [3:0]         ack_q, ack_d;
    logic               transmit_q, transmit_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               timeout_q, timeout_d;

    logic               rr_found;
    logic [1:0]         rr_idx;
    logic               launch;
    logic               echo_launch;
    logic               req_launch;
    logic               echo_pending;
    logic [7:0]         echo_tx_byte;

    // Search begins one past the last granted requester and wraps 3 -> 0.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = rr_ptr_q;
        for (int k = 1; k <= 4; k++) begin
            if (!rr_found && req[rr_ptr_q + 2'(k)]) begin
                rr_found = 1'b1;
                rr_idx   = rr_ptr_q + 2'(k);
            end
        end
    end

`ifdef UART_TX_ARB_ECHO_EN
    logic       echo_valid_q, echo_valid_d;
    logic [7:0] echo_byte_q, echo_byte_d;

    // A fresh receive always wins: it overwrites a full buffer and survives a coincident launch.
    always_comb begin
        echo_valid_d = echo_valid_q;
        echo_byte_d  = echo_byte_q;
        if (received) begin
            echo_valid_d = 1'b1;
            echo_byte_d  = rx_byte;
        end else if (echo_launch) begin
            echo_valid_d = 1'b0;
        end
    end

    always_ff @(posedge iCE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            echo_valid_q <= 1'b0;
            echo_byte_q  <= 8'h00;
        end else begin
            echo_valid_q <= echo_valid_d;
            echo_byte_q  <= echo_byte_d;
        end
    end

    assign echo_pending = echo_valid_q;
    assign echo_tx_byte = echo_byte_q;
`else
    logic unused_rx;
    assign unused_rx    = ^{received, rx_byte};
    assign echo_pending = 1'b0;
    assign echo_tx_byte = 8'h00;
`endif

    always_ff @(posedge iCE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rr_ptr_q   <= 2'd3;
            ack_q      <= 4'b0000;
            transmit_q <= 1'b0;
            tx_byte_q  <= 8'h00;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            ack_q      <= ack_d;
            transmit_q <= transmit_d;
            tx_byte_q  <= tx_byte_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (echo_pending || rr_found) state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (is_transmitting)        state_d = S_WAIT_DONE;
                else if (cnt_q >= CNT_LAST) state_d = S_IDLE;
            end
            S_WAIT_DONE: begin
                if (!is_transmitting) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        launch      = (state_q == S_IDLE) && (echo_pending || rr_found);
        echo_launch = launch && echo_pending;
        req_launch  = launch && !echo_pending;

        transmit_d = launch;
        ack_d      = req_launch ? (4'b0001 << rr_idx) : 4'b0000;
        rr_ptr_d   = req_launch ? rr_idx : rr_ptr_q;

        tx_byte_d = tx_byte_q;
        if (echo_launch)     tx_byte_d = echo_tx_byte;
        else if (req_launch) tx_byte_d = req_byte[{rr_idx, 3'b000} +: 8];

        timeout_d = (state_q == S_WAIT_START) && !is_transmitting && (cnt_q >= CNT_LAST);

        // Counter restarts on every launch and saturates while waiting for the start.
        cnt_d = cnt_q;
        if (launch)
            cnt_d = '0;
        else if ((state_q == S_WAIT_START) && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CNT_W'(1);
    end

    assign ack         = ack_q;
    assign transmit    = transmit_q;
    assign tx_byte     = tx_byte_q;
    assign timeout_err = timeout_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a launch scoreboard and a simple UART responder.
// Echo expectations follow UART_TX_ARB_ECHO_EN.
module tb_uart_tx_arbiter;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WD   = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_byte;
    logic [3:0]  ack;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        is_tx;
    logic        received;
    logic [7:0]  rx_byte;
    logic        busy;
    logic        timeout_err;
    logic [1:0]  dbg_state;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [11:0] exp_q[$];

    int uart_delay = 2;
    int uart_dur   = 10;
    bit uart_en    = 1'b1;

    // clock / reset
    always #5 clk = ~clk;

    uart_tx_arbiter #(.START_TIMEOUT(16)) dut (
        .iCE_CLK         (clk),
        .rst_n           (rst_n),
        .req             (req),
        .req_byte        (req_byte),
        .ack             (ack),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .is_transmitting (is_tx),
        .received        (received),
        .rx_byte         (rx_byte),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .dbg_state_o     (dbg_state)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_transmit(input string tag, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (transmit !== 1'b1 && n < budget);
        chk({tag, "_launch_seen"}, {31'd0, transmit}, 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (busy !== 1'b0 && n < budget);
        chk({tag, "_idle_seen"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"},      {28'd0, ack},         32'd0);
        chk({tag, "_transmit"}, {31'd0, transmit},    32'd0);
        chk({tag, "_tx_byte"},  {24'd0, tx_byte},     32'd0);
        chk({tag, "_busy"},     {31'd0, busy},        32'd0);
        chk({tag, "_timeout"},  {31'd0, timeout_err}, 32'd0);
        chk({tag, "_state"},    {30'd0, dbg_state},   {30'd0, ST_IDLE});
    endtask

    // UART responder: raises is_transmitting uart_delay cycles after transmit, for uart_dur cycles
    initial begin
        is_tx = 1'b0;
        forever begin
            @(negedge clk);
            if (transmit === 1'b1 && uart_en) begin
                repeat (uart_delay) @(negedge clk);
                is_tx = 1'b1;
                repeat (uart_dur) @(negedge clk);
                is_tx = 1'b0;
            end
        end
    end

    // scoreboard: every launch pops {ack, tx_byte}; no ack outside a launch; no back-to-back pulses
    logic        prev_tx = 1'b0;
    logic        prev_to = 1'b0;
    logic [11:0] mon_exp;
    always @(negedge clk) begin
        if (transmit === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL unexpected_launch: observed ack=%0h byte=%0h expected no launch", ack, tx_byte);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("launch_ack_byte", {20'd0, ack, tx_byte}, {20'd0, mon_exp});
            end
        end else begin
            chk("ack_without_launch", {28'd0, ack}, 32'd0);
        end
        if (prev_tx) chk("transmit_back_to_back", {31'd0, transmit}, 32'd0);
        if (prev_to) chk("timeout_back_to_back", {31'd0, timeout_err}, 32'd0);
        prev_tx = (transmit === 1'b1);
        prev_to = (timeout_err === 1'b1);
    end

    // directed sequence
    initial begin
        logic [7:0] rb[4];
        logic [3:0] oh;
        int         n;
        int         idx;

        rst_n    = 1'b0;
        req      = 4'b0000;
        req_byte = 32'd0;
        received = 1'b0;
        rx_byte  = 8'h00;
        for (int i = 0; i < 4; i++) rb[i] = 8'($urandom_range(0, 255));

        repeat (3) tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // single request, in-flight byte must ignore req_byte changes
        req_byte = 32'h0000_00A5;
        exp_q.push_back({4'b0001, 8'hA5});
        req = 4'b0001;
        wait_transmit("single", 5);
        chk("single_busy", {31'd0, busy}, 32'd1);
        req           = 4'b0000;
        req_byte[7:0] = 8'hFF;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy !== 1'b0 && n < 40);
        chk("single_busy_fall_cycles", n, 32'd13);
        chk("single_tx_hold", {24'd0, tx_byte}, 32'h0000_00A5);
        chk("single_state_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});

        // round robin from a fresh reset: grants 0,1,2,3,0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        uart_delay = 1;
        uart_dur   = 2;
        req_byte   = {rb[3], rb[2], rb[1], rb[0]};
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            exp_q.push_back({oh, rb[k % 4]});
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            idx = k % 4;
            wait_transmit("rr", 40);
            if (k == 4) begin
                req = 4'b0000;
            end else begin
                req[idx] = 1'b0;
                tick();
                req[idx] = 1'b1;
            end
        end
        wait_idle("rr", 40);

        // start timeout: requester 2, transmitter never starts
        uart_en = 1'b0;
        exp_q.push_back({4'b0100, rb[2]});
        req = 4'b0100;
        wait_transmit("timeout", 10);
        req = 4'b0000;
        n = 0;
        do begin
            tick();
            n++;
        end while (timeout_err !== 1'b1 && n < 40);
        chk("timeout_cycles", n, 32'd16);
        chk("timeout_state_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        tick();
        uart_en = 1'b1;

        // reset during WAIT_DONE
        uart_delay = 1;
        uart_dur   = 20;
        exp_q.push_back({4'b0001, rb[0]});
        req = 4'b0001;
        wait_transmit("midrst", 10);
        req = 4'b0000;
        repeat (3) tick();
        chk("midrst_in_wait_done", {30'd0, dbg_state}, {30'd0, ST_WD});
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (ack !== 4'b0000 || timeout_err !== 1'b0 || transmit !== 1'b0) n++;
        end
        chk("midrst_quiet_after_release", n, 32'd0);
        uart_dur = 2;
        exp_q.push_back({4'b0001, rb[0]});
        exp_q.push_back({4'b0010, rb[1]});
        req = 4'b0011;
        wait_transmit("postrst_first", 10);
        req[0] = 1'b0;
        wait_transmit("postrst_second", 20);
        req[1] = 1'b0;
        wait_idle("postrst", 20);

        // echo: buffered received byte goes ahead of a pending requester
        uart_delay = 1;
        uart_dur   = 6;
        exp_q.push_back({4'b0001, rb[0]});
`ifdef UART_TX_ARB_ECHO_EN
        exp_q.push_back({4'b0000, 8'h3C});
`endif
        exp_q.push_back({4'b0010, rb[1]});
        req = 4'b0001;
        wait_transmit("echo_pre", 10);
        req      = 4'b0010;
        received = 1'b1;
        rx_byte  = 8'h77;
        tick();
        rx_byte  = 8'h3C;
        tick();
        received = 1'b0;
        rx_byte  = 8'h00;
`ifdef UART_TX_ARB_ECHO_EN
        wait_transmit("echo_byte", 20);
        chk("echo_no_ack", {28'd0, ack}, 32'd0);
`endif
        wait_transmit("echo_req1", 30);
        req = 4'b0000;
        wait_idle("echo", 30);
        repeat (5) tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter START_TIMEOUT, default 16: cycles allowed from transmit pulse to is_transmitting rising.
REQ-002 SHALL have port iCE_CLK  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  4  per-requester level request, held until ack.
REQ-005 SHALL have port req_byte  input  32  byte for requester i on bits [8i+7:8i].
REQ-006 SHALL have port ack  output  4  one-cycle pulse on bit i when requester i's byte is accepted.
REQ-007 SHALL have port transmit  output  1  one-cycle start pulse to the UART transmitter.
REQ-008 SHALL have port tx_byte  output  8  byte presented to the UART transmitter.
REQ-009 SHALL have port is_transmitting  input  1  UART transmitter busy flag.
REQ-010 SHALL have port received  input  1  UART one-cycle byte-received strobe.
REQ-011 SHALL have port rx_byte  input  8  UART received byte.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port timeout_err  output  1  one-cycle pulse on start timeout.

Function
REQ-014 SHALL implement states IDLE, WAIT_START, WAIT_DONE.
REQ-015 IDLE with a pending source SHALL, in one cycle: register the selected byte into tx_byte, pulse transmit, pulse the matching ack bit (none for echo), enter WAIT_START.
REQ-016 Requester selection SHALL be round-robin: search starts at (last granted index + 1) mod 4, wraps 3->0; pointer updates only on a requester grant.
REQ-017 WAIT_START SHALL go to WAIT_DONE on the first cycle is_transmitting=1; the cycle counter SHALL clear on entry.
REQ-018 WAIT_START SHALL, after START_TIMEOUT cycles without is_transmitting, pulse timeout_err, drop the byte (ack is not repeated), and return to IDLE.
REQ-019 WAIT_DONE SHALL return to IDLE on the first cycle is_transmitting=0.
REQ-020 Next launch SHALL occur no earlier than the cycle after re-entering IDLE (at least one idle cycle between bytes).
REQ-021 Changes on req or req_byte outside IDLE SHALL have no effect on the byte in flight.
REQ-022 tx_byte SHALL hold its value until the next launch.
REQ-023 ack, transmit and timeout_err SHALL never be high for two consecutive cycles.
REQ-024 Counter width SHALL be clog2(START_TIMEOUT+1) bits; it SHALL saturate, never wrap.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, ack=0, transmit=0, tx_byte=8'h00, busy=0, timeout_err=0, RR pointer=3 (requester 0 searched first), echo buffer empty.
REQ-026 Reset mid-transfer SHALL abandon the byte with no ack or timeout_err after release; the first grant after release SHALL follow REQ-015.

Configuration
REQ-027 Macro UART_TX_ARB_ECHO_EN SHALL control received-byte echo.
REQ-028 With UART_TX_ARB_ECHO_EN defined: received=1 SHALL capture rx_byte into a one-entry echo buffer; a valid echo entry SHALL win over all requesters in IDLE and SHALL NOT move the RR pointer.
REQ-029 With echo enabled: a new received while the buffer is full SHALL overwrite it; received coincident with an echo launch SHALL launch the old byte and leave the new byte valid.
REQ-030 Without UART_TX_ARB_ECHO_EN: received and rx_byte SHALL be ignored and no echo storage SHALL be synthesized.

Verification
REQ-031 Single request: req=4'b0001, byte 8'hA5, is_transmitting high 2 cycles after transmit for 10 cycles -> ack=4'b0001 and transmit in the same cycle, tx_byte=8'hA5, busy returns low one cycle after is_transmitting falls.
REQ-032 Round-robin: req=4'b1111 held, each acked requester drops req the cycle after its ack then reasserts it -> grant order 0,1,2,3,0.
REQ-033 Timeout: req=4'b0100, is_transmitting held 0 -> timeout_err pulses 16 cycles after transmit, ack[2] pulses exactly once, state back to IDLE.
REQ-034 Reset mid-transfer: rst_n low during WAIT_DONE -> all outputs per REQ-025 same cycle; no ack after release until a new req.
REQ-035 Echo (macro defined): received with rx_byte=8'h3C while req=4'b0010 pending in IDLE -> 8'h3C transmitted first, then requester 1's byte; macro undefined -> requester 1 only.
